l2_data_ram_ctrl: RTL and testbench
===================================

Name: l2_data_ram_ctrl

Overview:
- Initiator-side controller for the single-port 1024x256 L2 data array macro (sp_d1024_w256).
- Accepts read/write requests from the L2 pipeline over a valid/ready channel and drives cs/we/addr/wdata/strobe to the array.
- Captures read data exactly one cycle after issue and returns it with its tag over a valid/ready response channel.
- Read issue is credit-limited so a stalled consumer never causes read data to be lost.

Parameters:
- ADDR_W, 10, array address width.
- DATA_W, 256, data width.
- STRB_W, 32, byte-strobe width (DATA_W/8).
- TAG_W, 4, request tag width, echoed on the response.
- RSP_DEPTH, 3, response FIFO entries. Minimum 1; 3 gives one read per cycle with rsp_ready_i held high.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_W  array address
- req_wdata_i  in  DATA_W  write data
- req_strb_i  in  STRB_W  byte write enables
- req_tag_i  in  TAG_W  read tag
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  consumer ready
- rsp_rdata_o  out  DATA_W  read data
- rsp_tag_o  out  TAG_W  tag of returned read
- ram_cs_o  out  1  array chip select
- ram_we_o  out  1  array write enable
- ram_addr_o  out  ADDR_W  array address
- ram_wdata_o  out  DATA_W  array write data
- ram_strb_o  out  STRB_W  array byte strobe
- ram_rdata_i  in  DATA_W  array read data, valid only in the cycle after a read issue
- busy_o  out  1  read in flight or response FIFO non-empty

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - The in-flight read flag (s1_vld), FIFO pointers and FIFO count clear to 0.
  - rsp_valid_o=0 and busy_o=0.
  - ram_cs_o and ram_we_o are forced 0 combinationally while rst_n_i is low.
  - req_ready_o=0 while rst_n_i is low.
  - A read in flight at reset is discarded; a mid-reset handshake on rsp is void.
- Credit: reserved = fifo_cnt + s1_vld.
  - req_ready_o = rst_n_i & (reserved < RSP_DEPTH).
  - The same condition gates writes, to keep the rule simple.
  - No pop look-ahead: a same-cycle rsp pop does not raise req_ready_o.
- Issue (cycle T, req_valid_i & req_ready_o):
  - ram_cs_o=1 and ram_we_o=req_write_i.
  - addr, wdata and strb pass through combinationally.
  - For reads, s1_vld<=1 and s1_tag<=req_tag_i.
  - With no handshake, ram_cs_o=0 and ram_we_o=0.
- Capture (cycle T+1, s1_vld=1): ram_rdata_i and s1_tag are pushed into the FIFO at the end of T+1.
  - The data must be captured in T+1 unconditionally: the array output mux select changes every cycle, so data is not held.
  - s1_vld clears unless a new read is issued in T+1.
- Response: rsp_valid_o = fifo_cnt != 0, registered FIFO head. First possible response is in T+2, so read latency is 2 cycles.
- Pop on rsp_valid_o & rsp_ready_i.
- Push and pop in the same cycle leave fifo_cnt unchanged; head/tail pointers advance and wrap modulo RSP_DEPTH.
- rsp_rdata_o and rsp_tag_o hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Writes generate no response and no credit; they occupy the array for one cycle only.
- Ordering: responses return in issue order. A read issued the cycle after a write to the same address returns the new data, which the array guarantees.
- busy_o = s1_vld | (fifo_cnt != 0).
- fifo_cnt width is $clog2(RSP_DEPTH+1); reserved never exceeds RSP_DEPTH. An assertion fires on overflow or underflow.

Decomposition:
- Package l2_ram_pkg holds:
  - L2_RAM_ADDR_W, L2_RAM_DATA_W, L2_RAM_STRB_W;
  - typedef l2_ram_req_t {write, addr, wdata, strb, tag};
  - typedef l2_ram_rsp_t {rdata, tag}.
- One sub-module is natural: l2_rsp_fifo, a parameterized synchronous FIFO with count output, instantiated with RSP_DEPTH entries of l2_ram_rsp_t.

Test Plan:
- Write addr 0x005, data pattern A, strb all-ones; then read 0x005, tag 3 -> ram_cs_o=1 and ram_we_o=1 in the write cycle; rsp_valid_o in read+2 with data A, tag 3.
- Bank select: write 0x1FF with B and 0x200 with C; then read 0x200, 0x1FF back-to-back -> responses C (first) then B, in order.
- Strobe merge: write 0x010 all-ones with 0; write 0x010 with strb=0x00000001, data 0xFF -> read returns byte0=0xFF, rest 0.
- Back-pressure: rsp_ready_i=0, issue 5 reads -> exactly 3 accepted, req_ready_o=0 after the third, ram_cs_o never asserted for the rest. Then rsp_ready_i=1 -> 3 responses drain in order, intact, and issue resumes.
- Throughput: rsp_ready_i=1 with 16 continuous reads -> one accept per cycle, 16 responses, tags in order.
- Reset mid-op: issue a read, assert rst_n_i low in T+1 -> no response ever appears, rsp_valid_o=0, busy_o=0 and req_ready_o=0 during reset; req_ready_o=1 after reset release.

Source files
------------

// File: rtl/l2_ram_pkg.sv
// Shared widths and request/response records for the L2 data array controller.
// The controller's parameter defaults come from here, so the records and ports stay in step.
package l2_ram_pkg;

  localparam int L2_RAM_ADDR_W = 10;
  localparam int L2_RAM_DATA_W = 256;
  localparam int L2_RAM_STRB_W = L2_RAM_DATA_W / 8;
  localparam int L2_RAM_TAG_W  = 4;

  typedef struct packed {
    logic                     write;
    logic [L2_RAM_ADDR_W-1:0] addr;
    logic [L2_RAM_DATA_W-1:0] wdata;
    logic [L2_RAM_STRB_W-1:0] strb;
    logic [L2_RAM_TAG_W-1:0]  tag;
  } l2_ram_req_t;

  typedef struct packed {
    logic [L2_RAM_DATA_W-1:0] rdata;
    logic [L2_RAM_TAG_W-1:0]  tag;
  } l2_ram_rsp_t;

endpackage

// File: rtl/l2_rsp_fifo.sv
// Small synchronous FIFO with occupancy count; head is read straight from storage.
// Pointers wrap modulo DEPTH, so any depth from 1 upward works.
module l2_rsp_fifo
  import l2_ram_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = l2_ram_rsp_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: the storage array is deliberately not reset; validity is defined by the
  // pointers and count alone, which keeps the entries plain enable flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all state here uses non-blocking assignment so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt == FULL));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && cnt == '0));

endmodule

// File: rtl/l2_data_ram_ctrl.sv
// Initiator-side controller for the single-port 1024x256 L2 data array.
// Reads are credit-limited against the response FIFO so unheld array data is never dropped.
module l2_data_ram_ctrl
  import l2_ram_pkg::*;
#(
  parameter int ADDR_W    = L2_RAM_ADDR_W,
  parameter int DATA_W    = L2_RAM_DATA_W,
  parameter int STRB_W    = L2_RAM_STRB_W,
  parameter int TAG_W     = L2_RAM_TAG_W,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [STRB_W-1:0] req_strb_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [STRB_W-1:0] ram_strb_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(RSP_DEPTH);

  l2_ram_req_t      req;
  l2_ram_rsp_t      push_data;
  l2_ram_rsp_t      head;
  logic             issue;
  logic             issue_rd;
  logic             pop;
  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   reserved;

  assign req = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i,
                 strb: req_strb_i, tag: req_tag_i};

  // A read holds its credit from issue until its response is popped; writes share the
  // gate only to keep the acceptance rule uniform.
  assign reserved    = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, s1_vld};
  assign req_ready_o = rst_n_i && (reserved < CREDITS);
  assign issue       = req_valid_i && req_ready_o;
  assign issue_rd    = issue && !req.write;

  assign ram_cs_o    = issue;
  assign ram_we_o    = issue && req.write;
  assign ram_addr_o  = req.addr;
  assign ram_wdata_o = req.wdata;
  assign ram_strb_o  = req.strb;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) s1_vld <= 1'b0;
    else          s1_vld <= issue_rd;
  end

  always_ff @(posedge clk_i) begin
    if (issue_rd) s1_tag <= req.tag;
  end

  // The array mux moves on every cycle, so capture happens whenever s1_vld is set,
  // independent of rsp_ready_i; the credit check guarantees room.
  assign push_data = '{rdata: ram_rdata_i, tag: s1_tag};
  assign pop       = rsp_valid_o && rsp_ready_i;

  l2_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (l2_ram_rsp_t)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (s1_vld),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign rsp_valid_o = (fifo_cnt != '0);
  assign rsp_rdata_o = head.rdata;
  assign rsp_tag_o   = head.tag;
  assign busy_o      = s1_vld || rsp_valid_o;

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    reserved <= CREDITS);

  a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_tag_o));

endmodule

// File: tb/tb_l2_data_ram_ctrl.sv
// Directed bench for l2_data_ram_ctrl: a behavioural array macro, an outstanding-read
// scoreboard checked every cycle, and literal expectations for each scenario.
module tb_l2_data_ram_ctrl;

  localparam int AW = 10;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int TW = 4;
  localparam int DEPTH = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_strb_i;
  logic [TW-1:0] req_tag_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic [TW-1:0] rsp_tag_o;
  logic          ram_cs_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [SW-1:0] ram_strb_o;
  logic [DW-1:0] ram_rdata_i;
  logic          busy_o;

  l2_data_ram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TAG_W(TW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_tag_i(req_tag_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_tag_o(rsp_tag_o), .ram_cs_o(ram_cs_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_strb_o(ram_strb_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } ent_t;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      cs_cnt = 0;
  int      vld_seen = 0;
  bit      chk_en = 1'b0;
  ent_t    sb[$];
  ent_t    got_q[$];
  logic [DW-1:0] mem [1024];

  localparam logic [DW-1:0] PAT_A = {8{32'hA5A5_5A5A}};
  localparam logic [DW-1:0] PAT_B = {8{32'h1234_5678}};
  localparam logic [DW-1:0] PAT_C = {8{32'hCAFE_F00D}};

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1;
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Array macro: one op per cycle; read data appears only in the cycle after a read.
  logic          p_cs, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_strb;

  always @(negedge clk_i) begin
    p_cs = ram_cs_o; p_we = ram_we_o; p_addr = ram_addr_o;
    p_wdata = ram_wdata_o; p_strb = ram_strb_o;
  end

  always @(posedge clk_i) begin
    if (p_cs === 1'b1 && p_we === 1'b1)
      for (int b = 0; b < SW; b++)
        if (p_strb[b]) mem[p_addr][b*8 +: 8] = p_wdata[b*8 +: 8];
    if (p_cs === 1'b1 && p_we === 1'b0) ram_rdata_i <= mem[p_addr];
    else                                ram_rdata_i <= {8{$urandom()}};
  end

  // Model: every accepted read is outstanding until popped; its response is visible
  // from two cycles after issue, in issue order, carrying the data current at issue.
  always @(negedge clk_i) begin
    bit exp_ready, exp_cs, exp_vld;
    if (chk_en) begin
      exp_ready = (rst_n_i === 1'b1) && (sb.size() < DEPTH);
      exp_cs    = (req_valid_i === 1'b1) && exp_ready;
      exp_vld   = (sb.size() != 0) && (cyc >= sb[0].cyc + 2);
      check("req_ready", DW'(req_ready_o), DW'(exp_ready));
      check("ram_cs", DW'(ram_cs_o), DW'(exp_cs));
      check("ram_we", DW'(ram_we_o), DW'(exp_cs && req_write_i));
      if (exp_cs) begin
        check("ram_addr", DW'(ram_addr_o), DW'(req_addr_i));
        check("ram_wdata", ram_wdata_o, req_wdata_i);
        check("ram_strb", DW'(ram_strb_o), DW'(req_strb_i));
      end
      check("rsp_valid", DW'(rsp_valid_o), DW'(exp_vld));
      if (exp_vld) begin
        check("rsp_rdata", rsp_rdata_o, sb[0].data);
        check("rsp_tag", DW'(rsp_tag_o), DW'(sb[0].tag));
      end
      check("busy", DW'(busy_o), DW'(sb.size() != 0));
      if (ram_cs_o === 1'b1) cs_cnt++;
      if (rsp_valid_o === 1'b1) vld_seen++;
      if (rst_n_i !== 1'b1) begin
        sb.delete();
      end else begin
        if (exp_vld && rsp_ready_i) begin
          got_q.push_back('{rsp_rdata_o, rsp_tag_o, cyc});
          void'(sb.pop_front());
        end
        if (exp_cs && !req_write_i) sb.push_back('{mem[req_addr_i], req_tag_i, cyc});
      end
    end
  end

  task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [TW-1:0] t,
                       output int icyc, output logic [1:0] cs_we);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a;
    req_wdata_i = d; req_strb_i = s; req_tag_i = t;
    icyc = -1; cs_we = 2'b00;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (req_ready_o === 1'b1) begin
        icyc = cyc; cs_we = {ram_cs_o, ram_we_o};
        break;
      end
      @(posedge clk_i); #1;
    end
    if (icyc < 0) check("op_timeout", 1'b0, 1'b1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic read_stream(input int n, input int first, input int budget,
                             input int a0, input int t0, output int acc);
    int idx;
    idx = first; acc = 0;
    for (int c = 0; c < budget && idx < n; c++) begin
      req_valid_i = 1'b1; req_write_i = 1'b0; req_strb_i = '0; req_wdata_i = '0;
      req_addr_i = AW'(a0 + idx); req_tag_i = TW'(t0 + idx);
      @(negedge clk_i);
      if (req_ready_o === 1'b1) begin acc++; idx++; end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 1'b0, 1'b1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, tw, acc;
    logic [1:0] cw;
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_strb_i = '0; req_tag_i = '0; rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk_en = 1'b1;
    @(negedge clk_i);
    check("reset_ready", DW'(req_ready_o), '0);
    check("reset_rsp_valid", DW'(rsp_valid_o), '0);
    check("reset_busy", DW'(busy_o), '0);
    @(posedge clk_i); #1 rst_n_i = 1'b1;

    // Write then read back with 2-cycle latency.
    got_q.delete();
    do_op(1'b1, 10'h005, PAT_A, '1, 4'd0, tw, cw);
    check("t1_write_cs_we", DW'(cw), DW'(2'b11));
    do_op(1'b0, 10'h005, '0, '0, 4'd3, ti, cw);
    check("t1_read_cs_we", DW'(cw), DW'(2'b10));
    wait_idle();
    check("t1_count", DW'(got_q.size()), DW'(1));
    if (got_q.size() == 1) begin
      check("t1_data", got_q[0].data, PAT_A);
      check("t1_tag", DW'(got_q[0].tag), DW'(4'd3));
      check("t1_latency", DW'(got_q[0].cyc - ti), DW'(2));
    end

    // Bank boundary, back-to-back reads returned in issue order.
    got_q.delete();
    do_op(1'b1, 10'h1FF, PAT_B, '1, 4'd0, tw, cw);
    do_op(1'b1, 10'h200, PAT_C, '1, 4'd0, tw, cw);
    do_op(1'b0, 10'h200, '0, '0, 4'd1, ti, cw);
    do_op(1'b0, 10'h1FF, '0, '0, 4'd2, tw, cw);
    check("t2_b2b_issue", DW'(tw - ti), DW'(1));
    wait_idle();
    check("t2_count", DW'(got_q.size()), DW'(2));
    if (got_q.size() == 2) begin
      check("t2_first", got_q[0].data, PAT_C);
      check("t2_second", got_q[1].data, PAT_B);
      check("t2_tags", DW'({got_q[0].tag, got_q[1].tag}), DW'(8'h12));
    end

    // Strobe merge: only byte 0 overwritten.
    got_q.delete();
    do_op(1'b1, 10'h010, '0, '1, 4'd0, tw, cw);
    do_op(1'b1, 10'h010, DW'(8'hFF), 32'h0000_0001, 4'd0, tw, cw);
    do_op(1'b0, 10'h010, '0, '0, 4'd7, ti, cw);
    wait_idle();
    check("t3_count", DW'(got_q.size()), DW'(1));
    if (got_q.size() == 1) check("t3_merge", got_q[0].data, DW'(8'hFF));

    // Back-pressure: only three reads fit while the consumer stalls.
    got_q.delete();
    rsp_ready_i = 1'b0;
    cs_cnt = 0;
    read_stream(5, 0, 8, 'h300, 8, acc);
    check("t4_accepted", DW'(acc), DW'(3));
    check("t4_cs_cycles", DW'(cs_cnt), DW'(3));
    check("t4_ready_low", DW'(req_ready_o), '0);
    rsp_ready_i = 1'b1;
    read_stream(5, 3, 30, 'h300, 8, acc);
    check("t4_resumed", DW'(acc), DW'(2));
    wait_idle();
    check("t4_count", DW'(got_q.size()), DW'(5));
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      check("t4_tag", DW'(got_q[i].tag), DW'(8 + i));
      check("t4_data", got_q[i].data, init_word('h300 + i));
    end

    // Throughput: one read per cycle with the consumer always ready.
    got_q.delete();
    read_stream(16, 0, 16, 'h100, 0, acc);
    check("t5_accepted", DW'(acc), DW'(16));
    wait_idle();
    check("t5_count", DW'(got_q.size()), DW'(16));
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      check("t5_tag", DW'(got_q[i].tag), DW'(i));
      check("t5_data", got_q[i].data, init_word('h100 + i));
    end

    // Reset in the cycle after a read issue discards it.
    got_q.delete();
    rsp_ready_i = 1'b0;
    do_op(1'b0, 10'h040, '0, '0, 4'd5, ti, cw);
    rst_n_i = 1'b0;
    vld_seen = 0;
    @(negedge clk_i);
    check("t6_ready_in_reset", DW'(req_ready_o), '0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t6_rsp_valid_reset", DW'(rsp_valid_o), '0);
    check("t6_busy_reset", DW'(busy_o), '0);
    check("t6_ready_reset", DW'(req_ready_o), '0);
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check("t6_ready_after", DW'(req_ready_o), DW'(1'b1));
    check("t6_no_rsp", DW'(got_q.size()), '0);
    check("t6_no_valid", DW'(vld_seen), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
